// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a
// first-word-fall-through receive FIFO with sticky overrun/framing flags.
module uart_rx #(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx,
    input  logic                             rd_en,
    input  logic                             err_clr,
    output logic [7:0]                       rd_data,
    output logic                             rx_empty,
    output logic                             rx_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_count,
    output logic                             overrun,
    output logic                             frame_err
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int NW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [NW-1:0] FULL_N  = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          rx_meta, rx_sync;
    logic          push_req, frame_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        push_req    = 1'b0;
        frame_set   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_M1;
                end
            end
            START: begin
                if (cnt == '0) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (!rx_sync) begin
                        state_nxt   = DATA;
                        cnt_nxt     = DIV_M1;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_nxt = {rx_sync, shreg[7:1]};
                    cnt_nxt   = DIV_M1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_idx_nxt = bit_idx + 3'd1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    push_req  = rx_sync;
                    frame_set = !rx_sync;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop  = rd_en && !rx_empty;
    assign push = push_req && (!rx_full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   rx_count <= rx_count + NW'(1);
                2'b01:   rx_count <= rx_count - NW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == FULL_N);
    assign rd_data  = rx_empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (push_req && rx_full && !pop) || (overrun && !err_clr);
            frame_err <= frame_set || (frame_err && !err_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a forked
// monitor pops the FIFO and compares head bytes against the queue.
module tb_uart_rx;

    localparam int DIV = 16;   // 1_000_000 / 60_000, truncated
    localparam int LAT = 155;  // sync 2 + idle 1 + half-bit 8 + 9 bit-times

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rx_empty, rx_full;
    logic [3:0] rx_count;
    logic       overrun, frame_err;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pop_cyc = 0;
    int         lat;
    bit         rd_allow = 1'b0;
    bit         rd_force = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(.CLK_FREQ(1_000_000), .BAUD(60_000), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(rd_data), .rx_empty(rx_empty), .rx_full(rx_full),
        .rx_count(rx_count), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic drain();
        int n;
        rd_allow = 1'b1;
        n = 0;
        while (!rx_empty && n < 600) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rd_allow = 1'b0;
        check("drain_empty", int'(rx_empty), 1);
        check("drain_queue_left", exp_q.size(), 0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        fork
            begin : monitor
                logic [7:0] e;
                forever begin
                    @(negedge clk);
                    if (!rst && !rx_empty && (rd_allow || cyc + 1 == pop_cyc)) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL pop_unexpected: got %02h expected no byte", rd_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (rd_data !== e) begin
                                errors++;
                                $display("FAIL pop_data: got %02h expected %02h", rd_data, e);
                            end
                        end
                        rd_en = 1'b1;
                    end else begin
                        rd_en = rd_force;
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_empty", int'(rx_empty), 1);
        check("rst_full", int'(rx_full), 0);
        check("rst_count", int'(rx_count), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_frame_err", int'(frame_err), 0);

        rd_force = 1'b1;
        repeat (3) @(negedge clk);
        rd_force = 1'b0;
        @(negedge clk);
        check("pop_empty_count", int'(rx_count), 0);
        check("pop_empty_flag", int'(rx_empty), 1);

        // single byte with latency measurement
        exp_q.push_back(8'hA5);
        fork
            send_byte(8'hA5, 1'b1);
            begin
                lat = 0;
                while (rx_empty && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("latency", lat, LAT);
        check("a5_count", int'(rx_count), 1);
        check("a5_overrun", int'(overrun), 0);
        check("a5_frame_err", int'(frame_err), 0);
        drain();

        // short low pulse rejected by START
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_empty", int'(rx_empty), 1);
        check("glitch_count", int'(rx_count), 0);
        check("glitch_frame_err", int'(frame_err), 0);
        check("glitch_overrun", int'(overrun), 0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        check("after_glitch_count", int'(rx_count), 1);
        drain();

        // framing error, with err_clr coinciding with the set event
        fork
            send_byte(8'h3C, 1'b0);
            begin
                repeat (LAT - 1) @(negedge clk);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                check("frame_err_set_wins", int'(frame_err), 1);
            end
        join
        repeat (20) @(negedge clk);
        check("frame_err_sticky", int'(frame_err), 1);
        check("frame_err_empty", int'(rx_empty), 1);
        pulse_err_clr();
        check("frame_err_cleared", int'(frame_err), 0);

        // nine bytes without reads: ninth dropped
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        check("ovf_full", int'(rx_full), 1);
        check("ovf_count", int'(rx_count), 8);
        check("ovf_overrun", int'(overrun), 1);
        check("ovf_frame_err", int'(frame_err), 0);
        pulse_err_clr();
        check("ovf_overrun_cleared", int'(overrun), 0);
        check("ovf_still_full", int'(rx_count), 8);
        drain();

        // full FIFO, pop coincides with ninth stop sample
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        check("pp_full_before", int'(rx_full), 1);
        exp_q.push_back(8'h09);
        pop_cyc = cyc + LAT;
        send_byte(8'h09, 1'b1);
        pop_cyc = 0;
        check("pp_count", int'(rx_count), 8);
        check("pp_full", int'(rx_full), 1);
        check("pp_overrun", int'(overrun), 0);
        drain();

        // reset mid-frame, flags cleared, then a clean byte
        send_byte(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        check("pre_rst_frame_err", int'(frame_err), 1);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (DIV) @(negedge clk);
        rx = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_count", int'(rx_count), 0);
        check("midrst_empty", int'(rx_empty), 1);
        check("midrst_frame_err", int'(frame_err), 0);
        repeat (10) @(negedge clk);
        exp_q.push_back(8'h66);
        send_byte(8'h66, 1'b1);
        check("midrst_66_count", int'(rx_count), 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
